// File: rtl/counter_sequencer.sv
// Start/stop/hold sequencer for a WIDTH-bit up-counter with one-shot and periodic modes.
// Optional prescaler enabled by defining COUNTER_SEQUENCER_PRESCALE_EN (adds PRE_W and prescale).
module counter_sequencer #(
   parameter int WIDTH = 4
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
   ,
   parameter int PRE_W = 4
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic             mode,
   input  logic [WIDTH-1:0] term_val,
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
   input  logic [PRE_W-1:0] prescale,
`endif
   output logic [WIDTH-1:0] Q,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] term_q, term_d;
   logic             mode_q, mode_d;
   logic             done_q, done_d;
   logic             tick;
   logic             adv;
   logic             at_term;
   logic             start_ok;

`ifdef COUNTER_SEQUENCER_PRESCALE_EN
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [PRE_W-1:0] pre_val_q, pre_val_d;

   assign tick = (pre_cnt_q == pre_val_q);
`else
   assign tick = 1'b1;
`endif

   // stop beats start in IDLE, so a simultaneous pair latches nothing
   assign start_ok = (state_q == IDLE) && start && !stop;
   assign adv      = (state_q == RUN) && !hold && tick;
   assign at_term  = (q_q == term_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_ok) state_d = RUN;
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (adv && at_term && !mode_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      tc   = adv && at_term;
      Q    = q_q;
      done = done_q;
   end

   always_comb begin
      q_d    = q_q;
      term_d = term_q;
      mode_d = mode_q;
      done_d = 1'b0;
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
      pre_cnt_d = pre_cnt_q;
      pre_val_d = pre_val_q;
`endif
      if (start_ok) begin
         term_d = term_val;
         mode_d = mode;
         q_d    = '0;
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
         pre_cnt_d = '0;
         pre_val_d = prescale;
`endif
      end else if (state_q == RUN) begin
         if (stop) begin
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
            pre_cnt_d = '0;
`endif
         end else if (!hold) begin
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
`endif
            if (adv) begin
               // wrap to zero is explicit; one-shot parks Q at the terminal value
               if (at_term) begin
                  if (mode_q) q_d = '0;
                  else        done_d = 1'b1;
               end else begin
                  q_d = q_q + WIDTH'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q    <= '0;
         term_q <= '0;
         mode_q <= 1'b0;
         done_q <= 1'b0;
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
         pre_cnt_q <= '0;
         pre_val_q <= '0;
`endif
      end else begin
         q_q    <= q_d;
         term_q <= term_d;
         mode_q <= mode_d;
         done_q <= done_d;
`ifdef COUNTER_SEQUENCER_PRESCALE_EN
         pre_cnt_q <= pre_cnt_d;
         pre_val_q <= pre_val_d;
`endif
      end
   end

endmodule
